a78_loader: RTL and testbench
=============================

Name: a78_loader

Overview:
- Write-side partner of the cart mapper. Receives the ROM image byte stream from the HPS download channel and writes payload bytes into cart ROM memory.
- Parses the optional 128-byte A78 header and publishes `cart_flags`/`cart_size` in the exact encoding the mapper consumes.
- Issues a cart reset pulse once a load completes.
- Sits between the HPS ioctl interface and the cart ROM memory (SDRAM/BRAM) write port.

Parameters:
- ADDR_W, 18, width of the ROM byte address (256 KiB window).
- HEADER_LEN, 128, A78 header length in bytes.
- RESET_HOLD, 64, clock cycles `cart_reset` stays high after a load finishes.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high for the duration of a file transfer.
- has_header  in  1  file carries an A78 header; sampled on the rising edge of `ioctl_download`.
- ioctl_wr  in  1  single-cycle strobe; byte valid on `ioctl_addr`/`ioctl_dout`.
- ioctl_addr  in  25  file byte offset.
- ioctl_dout  in  8  file byte.
- ioctl_wait  out  1  stall request to the HPS.
- mem_addr  out  ADDR_W  ROM write address.
- mem_data  out  8  ROM write data.
- mem_we  out  1  write request; held until `mem_ack`.
- mem_ack  in  1  single-cycle write completion.
- cart_flags  out  10  mapper flags.
- cart_size  out  32  ROM payload size in bytes.
- load_done  out  1  one-cycle pulse at end of load.
- load_error  out  1  sticky until next download start.
- cart_reset  out  1  holds console/mapper in reset.

Behaviour:
- Reset values:
  - `mem_we`, `ioctl_wait`, `load_done`, `load_error`, `cart_reset` = 0.
  - `cart_flags` = 0, `cart_size` = 0, `mem_addr`/`mem_data` = 0.
  - FSM = IDLE.
- FSM states: IDLE, RECV, WRITE, HOLD.
- IDLE:
  - On a rising edge of `ioctl_download`: latch `has_header`, clear the byte counter, the header shadow and `load_error`; set `cart_reset`=1; go to RECV.
  - `ioctl_wr` strobes in IDLE are ignored.
- RECV, on `ioctl_wr`:
  - When `has_header`=1 and `ioctl_addr` < HEADER_LEN: store the byte in the header shadow (only offsets 1..9 and 0x31..0x36 are kept). No memory write.
  - Otherwise: payload index = `ioctl_addr` − (`has_header` ? HEADER_LEN : 0).
    - If the index is ≥ 2^ADDR_W: drop the byte and set `load_error`.
    - Else: the next cycle drives `mem_addr`=index, `mem_data`=byte, `mem_we`=1, `ioctl_wait`=1, and enters WRITE. Payload count = max(count, index+1).
- WRITE:
  - `mem_we` and `ioctl_wait` stay high until the `mem_ack` cycle. Both drop the following cycle; return to RECV.
  - An `ioctl_wr` arriving in WRITE is dropped and sets `load_error`.
- Falling edge of `ioctl_download` (from RECV, or from WRITE once the ack has arrived): all outputs update atomically in one cycle.
  - If `has_header` and the signature at offsets 1..9 equals "ATARI7800":
    - `cart_size` = big-endian bytes 0x31..0x34.
    - `cart_flags[7:0]` = byte 0x36.
    - `cart_flags[8]` = byte 0x35 bit1 (Activision).
    - `cart_flags[9]` = byte 0x35 bit0 (Absolute).
  - If `has_header` and the signature is bad: `load_error`=1, `cart_flags`=0, `cart_size`=payload count.
  - If headerless: `cart_flags`=0, `cart_size`=payload count.
  - In all cases pulse `load_done` and go to HOLD.
- HOLD: counter runs RESET_HOLD cycles, then `cart_reset`=0 and return to IDLE. A new download rising edge in HOLD restarts from IDLE-entry behaviour.
- During RECV/WRITE, `cart_flags`/`cart_size` keep their previous values; the mapper never sees partial data.
- `reset` mid-operation: everything returns to reset values, including an in-flight `mem_we`. A download in progress is abandoned until the next rising edge of `ioctl_download`.
- Latency: `ioctl_wr` → `mem_we` = 1 cycle; `mem_ack` → `ioctl_wait` low = 1 cycle.

Optional Feature:
- Macro: A78_SIZE_CHECK_EN.
- Defined: for a valid header, if the header size differs from the payload count, set `load_error`=1. `cart_size` still takes the header value.
- Undefined: no comparison is made; `load_error` is driven only by signature, overflow and dropped-strobe conditions.

Decomposition:
- Package `a78_pkg` holds:
  - state enum;
  - header offsets: SIG 1..9, SIZE 0x31..0x34, TYPE_HI 0x35, TYPE_LO 0x36;
  - the signature constant;
  - `cart_flags` bit-index constants, shared with the mapper.
- One combinational sub-module, `a78_header_decode`: header shadow → `sig_ok`, `size`, `flags`.

Test Plan:
- SuperGame load: `has_header`=1, valid sig, size 0x00020000, type 0x0002, 0x20000 payload bytes → `cart_size`=0x20000, `cart_flags`=10'h002. File byte 128 is written at `mem_addr` 0 and the last write is at 0x1FFFF; `load_done` pulses once; `cart_reset` falls 64 cycles later.
- Headerless 48K: 0xC000 bytes with `has_header`=0 → `cart_size`=0xC000, `cart_flags`=0, last `mem_addr`=0xBFFF.
- Activision header: type bytes 0x35=0x02, 0x36=0x00 → `cart_flags`=10'h100.
- Bad signature ("ATARI7801"), 0x8000 payload bytes → `load_error`=1, `cart_flags`=0, `cart_size`=0x8000.
- Slow memory: `mem_ack` arrives 5 cycles after `mem_we` → `ioctl_wait` high for 6 cycles and exactly one write. A strobe injected mid-WRITE is dropped and sets `load_error`.
- `reset` asserted after 100 payload bytes → `mem_we`=0 and `cart_flags`/`cart_size`=0 next cycle. Further strobes are ignored until a new `ioctl_download` rising edge.

Source files
------------

// File: rtl/a78_loader_pkg.sv
// ============================================================================
// a78_pkg : shared types and constants for the A78 loader and cart mapper
// Revision: 1.0
// ============================================================================
`default_nettype none

package a78_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Header byte offsets
    localparam int c_hdr_sig_first  = 1;
    localparam int c_hdr_sig_len    = 9;
    localparam int c_hdr_size_first = 8'h31;
    localparam int c_hdr_size_len   = 4;
    localparam int c_hdr_type_hi    = 8'h35;
    localparam int c_hdr_type_lo    = 8'h36;

    // Element 0 is the byte at offset 1
    localparam logic [0:8][7:0] c_a78_signature = "ATARI7800";

    // cart_flags bit layout consumed by the mapper
    localparam int c_flags_w         = 10;
    localparam int c_flag_activision = 8;
    localparam int c_flag_absolute   = 9;

    typedef struct packed {
        logic [0:8][7:0] sig;
        logic [0:3][7:0] size;
        logic [7:0]      type_hi;
        logic [7:0]      type_lo;
    } a78_header_t;

endpackage

`default_nettype wire

// File: rtl/a78_loader_header_decode.sv
// ============================================================================
// a78_header_decode : header shadow -> signature check, ROM size, mapper flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module a78_header_decode
    import a78_pkg::*;
(
    input  a78_header_t          hdr,
    output logic                 sig_ok,
    output logic [31:0]          size,
    output logic [c_flags_w-1:0] flags
);

    logic w_unused_type_bits;
    assign w_unused_type_bits = ^hdr.type_hi[7:2];

    always_comb begin
        sig_ok                   = (hdr.sig == c_a78_signature);
        size                     = hdr.size;
        flags                    = '0;
        flags[7:0]               = hdr.type_lo;
        flags[c_flag_activision] = hdr.type_hi[1];
        flags[c_flag_absolute]   = hdr.type_hi[0];
    end

endmodule

`default_nettype wire

// File: rtl/a78_loader.sv
// ============================================================================
// a78_loader : HPS ioctl download -> cart ROM writer with A78 header parsing.
// Optional macro A78_SIZE_CHECK_EN flags header size vs payload size mismatch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module a78_loader
    import a78_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int HEADER_LEN = 128,
    parameter int RESET_HOLD = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic                 has_header,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [7:0]           mem_data,
    output logic                 mem_we,
    input  logic                 mem_ack,
    output logic [c_flags_w-1:0] cart_flags,
    output logic [31:0]          cart_size,
    output logic                 load_done,
    output logic                 load_error,
    output logic                 cart_reset
);

    localparam int c_hold_w = $clog2(RESET_HOLD + 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RESET_HOLD - 1);

    state_t                 r_state, w_state_nxt;
    logic                   r_dl_prev;
    logic                   r_has_hdr;
    a78_header_t            r_hdr;
    logic [ADDR_W:0]        r_count;
    logic [c_hold_w-1:0]    r_hold_cnt;
    logic                   r_mem_we, r_wait, r_load_done, r_load_error, r_cart_reset;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [7:0]             r_mem_data;
    logic [c_flags_w-1:0]   r_cart_flags;
    logic [31:0]            r_cart_size;

    logic                   w_dl_rise, w_in_hdr, w_ovf;
    logic [24:0]            w_idx;
    logic [ADDR_W:0]        w_idx_p1;
    logic                   w_start, w_hdr_wr, w_pay_wr, w_err_set, w_finish, w_hold_done;
    logic                   w_sig_ok;
    logic [31:0]            w_hdr_size;
    logic [c_flags_w-1:0]   w_hdr_flags;

    assign w_dl_rise = ioctl_download && !r_dl_prev;
    assign w_in_hdr  = r_has_hdr && (ioctl_addr < 25'(HEADER_LEN));
    assign w_idx     = ioctl_addr - (r_has_hdr ? 25'(HEADER_LEN) : 25'd0);
    assign w_ovf     = |w_idx[24:ADDR_W];
    assign w_idx_p1  = {1'b0, w_idx[ADDR_W-1:0]} + 1'b1;

    a78_header_decode u_decode (
        .hdr    (r_hdr),
        .sig_ok (w_sig_ok),
        .size   (w_hdr_size),
        .flags  (w_hdr_flags)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_hdr_wr    = 1'b0;
        w_pay_wr    = 1'b0;
        w_err_set   = 1'b0;
        w_finish    = 1'b0;
        w_hold_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dl_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (!ioctl_download) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (ioctl_wr) begin
                    if (w_in_hdr) begin
                        w_hdr_wr = 1'b1;
                    end else if (w_ovf) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_pay_wr    = 1'b1;
                        w_state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // The HPS should be stalled; a strobe here is lost data
                if (ioctl_wr) w_err_set = 1'b1;
                if (mem_ack) w_state_nxt = ST_RECV;
            end
            ST_HOLD: begin
                if (w_dl_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RECV;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_hold_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            // A download still high across reset must not look like a new edge
            r_dl_prev    <= ioctl_download;
            r_has_hdr    <= 1'b0;
            r_hdr        <= '0;
            r_count      <= '0;
            r_hold_cnt   <= '0;
            r_mem_we     <= 1'b0;
            r_wait       <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_cart_reset <= 1'b0;
            r_cart_flags <= '0;
            r_cart_size  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dl_prev   <= ioctl_download;
            r_load_done <= w_finish;

            if (w_start) begin
                r_has_hdr    <= has_header;
                r_count      <= '0;
                r_hdr        <= '0;
                r_load_error <= 1'b0;
                r_cart_reset <= 1'b1;
            end

            if (w_hdr_wr) begin
                for (int i = 0; i < c_hdr_sig_len; i++)
                    if (ioctl_addr == 25'(c_hdr_sig_first + i)) r_hdr.sig[i] <= ioctl_dout;
                for (int i = 0; i < c_hdr_size_len; i++)
                    if (ioctl_addr == 25'(c_hdr_size_first + i)) r_hdr.size[i] <= ioctl_dout;
                if (ioctl_addr == 25'(c_hdr_type_hi)) r_hdr.type_hi <= ioctl_dout;
                if (ioctl_addr == 25'(c_hdr_type_lo)) r_hdr.type_lo <= ioctl_dout;
            end

            if (w_err_set) r_load_error <= 1'b1;

            if (w_pay_wr) begin
                r_mem_addr <= w_idx[ADDR_W-1:0];
                r_mem_data <= ioctl_dout;
                r_mem_we   <= 1'b1;
                r_wait     <= 1'b1;
                if (w_idx_p1 > r_count) r_count <= w_idx_p1;
            end else if (r_state == ST_WRITE && mem_ack) begin
                r_mem_we <= 1'b0;
                r_wait   <= 1'b0;
            end

            if (w_finish) begin
                r_hold_cnt <= '0;
                if (r_has_hdr && w_sig_ok) begin
                    r_cart_size  <= w_hdr_size;
                    r_cart_flags <= w_hdr_flags;
`ifdef A78_SIZE_CHECK_EN
                    if (w_hdr_size != 32'(r_count)) r_load_error <= 1'b1;
`endif
                end else begin
                    r_cart_size  <= 32'(r_count);
                    r_cart_flags <= '0;
                    if (r_has_hdr) r_load_error <= 1'b1;
                end
            end else if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if (w_hold_done) r_cart_reset <= 1'b0;
        end
    end

    assign ioctl_wait = r_wait;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_we     = r_mem_we;
    assign cart_flags = r_cart_flags;
    assign cart_size  = r_cart_size;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;
    assign cart_reset = r_cart_reset;

endmodule

`default_nettype wire

// File: tb/tb_a78_loader.sv
// ============================================================================
// tb_a78_loader : directed self-checking bench for a78_loader
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_a78_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        has_header = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic [17:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic [9:0]  cart_flags;
    logic [31:0] cart_size;
    logic        load_done;
    logic        load_error;
    logic        cart_reset;

    int n_cmp = 0;
    int n_bad = 0;
    int we_rises = 0;
    logic we_q = 1'b0;

    a78_loader dut (
        .clock          (clock),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .has_header     (has_header),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_we         (mem_we),
        .mem_ack        (mem_ack),
        .cart_flags     (cart_flags),
        .cart_size      (cart_size),
        .load_done      (load_done),
        .load_error     (load_error),
        .cart_reset     (cart_reset)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we && !we_q) we_rises++;
        we_q <= mem_we;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl(input logic hdr);
        has_header     = hdr;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic send_header(input logic [71:0] sig, input logic [31:0] sz,
                               input logic [7:0] th, input logic [7:0] tl);
        logic [7:0] b;
        for (int i = 0; i < 128; i++) begin
            b = 8'hEE;
            if (i >= 1 && i <= 9)            b = sig[71-8*(i-1) -: 8];
            else if (i >= 'h31 && i <= 'h34) b = sz[31-8*(i-'h31) -: 8];
            else if (i == 'h35)              b = th;
            else if (i == 'h36)              b = tl;
            strobe(25'(i), b);
        end
    endtask

    // One payload byte with memory ack after lat cycles; optional strobe mid-WRITE
    task automatic pay(input logic [24:0] a, input logic [7:0] d, input logic [31:0] exp_addr,
                       input int lat, input bit inject, output int wait_cyc);
        strobe(a, d);
        chk("mem_we_rise", 32'(mem_we), 32'd1);
        chk("mem_addr", 32'(mem_addr), exp_addr);
        chk("mem_data", 32'(mem_data), 32'(d));
        wait_cyc = 0;
        for (int i = 0; i < lat; i++) begin
            if (ioctl_wait) wait_cyc++;
            if (inject && i == 2) begin
                ioctl_addr = a + 25'd1;
                ioctl_wr   = 1'b1;
            end
            tick();
            ioctl_wr = 1'b0;
        end
        if (ioctl_wait) wait_cyc++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("wait_drop", 32'(ioctl_wait), 32'd0);
        chk("we_drop", 32'(mem_we), 32'd0);
    endtask

    task automatic finish_dl(input logic [31:0] exp_size, input logic [31:0] exp_flags,
                             input logic exp_err);
        int n;
        int extra;
        ioctl_download = 1'b0;
        tick();
        chk("load_done", 32'(load_done), 32'd1);
        chk("cart_size", cart_size, exp_size);
        chk("cart_flags", 32'(cart_flags), exp_flags);
        chk("load_error", 32'(load_error), 32'(exp_err));
        n = 0;
        extra = 0;
        do begin
            tick();
            n++;
            if (load_done) extra++;
        end while (cart_reset && n < 200);
        chk("reset_hold", 32'(n), 32'd64);
        chk("done_once", 32'(extra), 32'd0);
    endtask

    initial begin
        int wc;
        int rises0;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(load_error), 0);
        chk("rst_creset", 32'(cart_reset), 0);
        chk("rst_flags", 32'(cart_flags), 0);
        chk("rst_size", cart_size, 0);
        chk("rst_maddr", 32'(mem_addr), 0);
        chk("rst_mdata", 32'(mem_data), 0);

        // Strobe in IDLE ignored
        strobe(25'd5, 8'h99);
        chk("idle_ignore", 32'(mem_we), 0);

        // SuperGame with header (sparse payload: first and last byte)
        start_dl(1'b1);
        chk("sg_creset", 32'(cart_reset), 1);
        send_header("ATARI7800", 32'h0002_0000, 8'h00, 8'h02);
        chk("sg_hdr_nowrite", 32'(we_rises), 0);
        pay(25'd128, 8'h11, 32'h0, 0, 1'b0, wc);
        pay(25'h2007F, 8'h5A, 32'h1FFFF, 0, 1'b0, wc);
        finish_dl(32'h0002_0000, 32'h002, 1'b0);

        // Headerless 48K, plus an out-of-window byte
        start_dl(1'b0);
        chk("keep_flags", 32'(cart_flags), 32'h002);
        chk("keep_size", cart_size, 32'h0002_0000);
        pay(25'd0, 8'hA5, 32'h0, 0, 1'b0, wc);
        pay(25'hBFFF, 8'h3C, 32'hBFFF, 0, 1'b0, wc);
        chk("nl_err_clean", 32'(load_error), 0);
        strobe(25'h40000, 8'h77);
        chk("ovf_nowrite", 32'(mem_we), 0);
        chk("ovf_err", 32'(load_error), 1);
        finish_dl(32'h0000_C000, 32'h000, 1'b1);

        // Activision header
        start_dl(1'b1);
        chk("err_cleared", 32'(load_error), 0);
        send_header("ATARI7800", 32'h0000_8000, 8'h02, 8'h00);
        pay(25'(128 + 'h7FFF), 8'hC3, 32'h7FFF, 0, 1'b0, wc);
        finish_dl(32'h0000_8000, 32'h100, 1'b0);

        // Bad signature
        start_dl(1'b1);
        send_header("ATARI7801", 32'h0001_0000, 8'h01, 8'h05);
        pay(25'(128 + 'h7FFF), 8'h3E, 32'h7FFF, 0, 1'b0, wc);
        chk("bad_err_pre", 32'(load_error), 0);
        finish_dl(32'h0000_8000, 32'h000, 1'b1);

        // Slow memory with a strobe injected mid-WRITE
        start_dl(1'b0);
        rises0 = we_rises;
        pay(25'h10, 8'h77, 32'h10, 5, 1'b1, wc);
        chk("slow_wait_cyc", 32'(wc), 32'd6);
        tick();
        chk("slow_one_write", 32'(we_rises - rises0), 32'd1);
        chk("slow_err", 32'(load_error), 1);
        finish_dl(32'h0000_0011, 32'h000, 1'b1);

        // Reset mid-download
        start_dl(1'b0);
        for (int i = 0; i < 100; i++) pay(25'(i), 8'(i), 32'(i), 0, 1'b0, wc);
        strobe(25'd100, 8'h64);
        chk("pre_rst_we", 32'(mem_we), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_flags", 32'(cart_flags), 0);
        chk("mid_rst_size", cart_size, 0);
        tick();
        strobe(25'd200, 8'h55);
        chk("post_rst_ignore", 32'(mem_we), 0);
        ioctl_download = 1'b0;
        tick();
        chk("post_rst_nodone", 32'(load_done), 0);
        start_dl(1'b0);
        chk("restart_creset", 32'(cart_reset), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
